// File: rtl/fft_fixed_pkg.sv
// Shared fixed-point definitions for the FFT twiddle stage: word width,
// fractional bits, word/tag typedefs, scheduler states and saturation limits.
package fft_fixed_pkg;

  localparam int N = 16;
  localparam int Q = 8;

  typedef logic [N-1:0] fx_t;

  // Product tag: identifies which of the four partial products a result is.
  typedef logic [1:0] tag_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUT
  } state_e;

  localparam fx_t SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam fx_t SAT_MIN = {1'b1, {(N-1){1'b0}}};

endpackage

// File: rtl/fixed_mul_pipe.sv
// Sign-magnitude truncating fixed-point multiplier with exactly MUL_LAT
// register stages. A valid bit and a 2-bit product tag travel with each product.
module fixed_mul_pipe
  import fft_fixed_pkg::*;
#(
  parameter int N       = fft_fixed_pkg::N,
  parameter int Q       = fft_fixed_pkg::Q,
  parameter int MUL_LAT = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  tag_t         i_tag,
  output logic         o_valid,
  output logic [N-1:0] o_p,
  output tag_t         o_tag
);

  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic [2*N-1:0] prod;
  logic [N-1:0]   trunc;
  logic [N-1:0]   prod_s;

  logic [N-1:0] p_q   [MUL_LAT];
  logic         vld_q [MUL_LAT];
  tag_t         tag_q [MUL_LAT];

  // Magnitude multiply, keep bits [N-1+Q:Q] (truncation toward zero), re-apply sign.
  always_comb begin
    // NOTE: always_comb uses blocking '=' and assigns every output on every path, so no latch is inferred.
    mag_a  = i_a[N-1] ? (~i_a + 1'b1) : i_a;
    mag_b  = i_b[N-1] ? (~i_b + 1'b1) : i_b;
    prod   = {{N{1'b0}}, mag_a} * {{N{1'b0}}, mag_b};
    trunc  = N'(prod >> Q);
    prod_s = (i_a[N-1] ^ i_b[N-1]) ? (~trunc + 1'b1) : trunc;
  end

  // Pipeline stages; all cleared on reset so no in-flight product survives a flush.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the stage arrays are reset element by element because a stale valid bit must never escape a flush.
      for (int i = 0; i < MUL_LAT; i++) begin
        p_q[i]   <= '0;
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every stage samples the previous stage's old value.
      p_q[0]   <= prod_s;
      vld_q[0] <= i_valid;
      tag_q[0] <= i_tag;
      for (int i = 1; i < MUL_LAT; i++) begin
        p_q[i]   <= p_q[i-1];
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign o_p     = p_q[MUL_LAT-1];
  assign o_valid = vld_q[MUL_LAT-1];
  assign o_tag   = tag_q[MUL_LAT-1];

endmodule

// File: rtl/cmul_scheduler.sv
// Complex multiplier (a * w) for the FFT twiddle stage. The four real products
// share one pipelined multiplier and are recombined into Q-format results.
// Optional macro CMUL_SATURATE_EN: saturating k1/k3 accumulation plus o_ovf.
module cmul_scheduler
  import fft_fixed_pkg::*;
#(
  parameter int N       = fft_fixed_pkg::N,
  parameter int Q       = fft_fixed_pkg::Q,
  parameter int MUL_LAT = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a_re,
  input  logic [N-1:0] i_a_im,
  input  logic [N-1:0] i_w_re,
  input  logic [N-1:0] i_w_im,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_re,
  output logic [N-1:0] o_im
`ifdef CMUL_SATURATE_EN
  ,
  output logic         o_ovf
`endif
);

  state_e state_q, state_d;
  tag_t   issue_cnt_q, issue_cnt_d;
  tag_t   ret_cnt_q;

  logic [N-1:0] a_re_q, a_im_q, w_re_q, w_im_q;
  logic [N-1:0] re_acc_q, re_acc_d;
  logic [N-1:0] im_acc_q, im_acc_d;

  logic [N-1:0] mul_a, mul_b;
  logic         mul_vld;
  logic         prod_vld;
  logic [N-1:0] prod;
  tag_t         prod_tag;
  logic         accept;

  logic [N-1:0] re_sub;
  logic [N-1:0] im_add;

`ifdef CMUL_SATURATE_EN
  localparam logic [N-1:0] SAT_HI = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_LO = {1'b1, {(N-1){1'b0}}};
  logic ovf_q, ovf_d;
  logic re_ovf, im_ovf;
`endif

  assign accept  = i_valid && (state_q == IDLE);
  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == OUT);
  assign o_re    = re_acc_q;
  assign o_im    = im_acc_q;
`ifdef CMUL_SATURATE_EN
  assign o_ovf   = ovf_q;
`endif

  // FSM next state and issue counter.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d     = ISSUE;
          issue_cnt_d = '0;
        end
      end
      ISSUE: begin
        issue_cnt_d = issue_cnt_q + 2'd1;
        if (issue_cnt_q == 2'd3) state_d = DRAIN;
      end
      DRAIN: begin
        if (prod_vld && prod_tag == 2'd3) state_d = OUT;
      end
      OUT: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and issue-counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  // Operand capture on accept; held until the next accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_re_q <= '0;
      a_im_q <= '0;
      w_re_q <= '0;
      w_im_q <= '0;
    end else if (accept) begin
      a_re_q <= i_a_re;
      a_im_q <= i_a_im;
      w_re_q <= i_w_re;
      w_im_q <= i_w_im;
    end
  end

  // Operand mux: k0 a_re*w_re, k1 a_im*w_im, k2 a_re*w_im, k3 a_im*w_re.
  always_comb begin
    mul_a = a_re_q;
    mul_b = w_re_q;
    unique case (issue_cnt_q)
      2'd1:    begin mul_a = a_im_q; mul_b = w_im_q; end
      2'd2:    begin mul_a = a_re_q; mul_b = w_im_q; end
      2'd3:    begin mul_a = a_im_q; mul_b = w_re_q; end
      default: begin mul_a = a_re_q; mul_b = w_re_q; end
    endcase
  end

  assign mul_vld = (state_q == ISSUE);

  fixed_mul_pipe #(
    .N       (N),
    .Q       (Q),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (mul_vld),
    .i_a     (mul_a),
    .i_b     (mul_b),
    .i_tag   (issue_cnt_q),
    .o_valid (prod_vld),
    .o_p     (prod),
    .o_tag   (prod_tag)
  );

  assign re_sub = re_acc_q - prod;
  assign im_add = im_acc_q + prod;

`ifdef CMUL_SATURATE_EN
  assign re_ovf = (re_acc_q[N-1] != prod[N-1]) && (re_sub[N-1] != re_acc_q[N-1]);
  assign im_ovf = (im_acc_q[N-1] == prod[N-1]) && (im_add[N-1] != im_acc_q[N-1]);
`endif

  // Accumulator update, selected by the returned-product counter.
  always_comb begin
    re_acc_d = re_acc_q;
    im_acc_d = im_acc_q;
`ifdef CMUL_SATURATE_EN
    ovf_d    = accept ? 1'b0 : ovf_q;
`endif
    if (prod_vld) begin
      unique case (ret_cnt_q)
        2'd0: re_acc_d = prod;
        2'd1: begin
          re_acc_d = re_sub;
`ifdef CMUL_SATURATE_EN
          if (re_ovf) begin
            re_acc_d = re_acc_q[N-1] ? SAT_LO : SAT_HI;
            ovf_d    = 1'b1;
          end
`endif
        end
        2'd2: im_acc_d = prod;
        default: begin
          im_acc_d = im_add;
`ifdef CMUL_SATURATE_EN
          if (im_ovf) begin
            im_acc_d = im_acc_q[N-1] ? SAT_LO : SAT_HI;
            ovf_d    = 1'b1;
          end
`endif
        end
      endcase
    end
  end

  // Accumulator, overflow flag and returned-product counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      re_acc_q  <= '0;
      im_acc_q  <= '0;
      ret_cnt_q <= '0;
`ifdef CMUL_SATURATE_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      re_acc_q <= re_acc_d;
      im_acc_q <= im_acc_d;
      if (prod_vld) ret_cnt_q <= ret_cnt_q + 2'd1;
`ifdef CMUL_SATURATE_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

endmodule
